// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: captures MEM results for the writeback mux and
// tracks retirement (valid bit, HALT latch, 16-bit retired-instruction count).
module mem_wb_stage_reg #(
    parameter int N  = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic [N-1:0]  mem_alu_out,
    input  logic [N-1:0]  mem_rd_data,
    input  logic          mem_mem_to_reg,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] mem_wr_reg,
    input  logic          mem_halt,
    output logic          wb_valid,
    output logic [N-1:0]  wb_alu_out,
    output logic [N-1:0]  wb_mem_out,
    output logic          wb_mem_to_reg,
    output logic          wb_reg_write,
    output logic [RW-1:0] wb_wr_reg,
    output logic          halted,
    output logic [15:0]   retire_cnt
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  alu_q, alu_d;
    logic [N-1:0]  mem_q, mem_d;
    logic          m2r_q, m2r_d;
    logic          rw_q, rw_d;
    logic [RW-1:0] wr_q, wr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          retire;

    // A retirement is a non-stalled, non-flushed load of a real instruction.
    assign retire = (state_q == RUN) && !stall && !flush && mem_valid;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (retire && mem_halt) state_d = HALT;
    end

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        m2r_d   = m2r_q;
        rw_d    = rw_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    alu_d   = mem_alu_out;
                    mem_d   = mem_rd_data;
                    m2r_d   = mem_mem_to_reg;
                    wr_d    = mem_wr_reg;
                    valid_d = mem_valid && !flush;
                    rw_d    = mem_reg_write && mem_valid && !flush;
                end
                if (retire) cnt_d = cnt_q + 16'd1;
            end
            // Halted: stall is ignored so HALT shows on wb_* for exactly one cycle.
            HALT: begin
                valid_d = 1'b0;
                rw_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            mem_q   <= '0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            m2r_q   <= m2r_d;
            rw_q    <= rw_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_alu_out    = alu_q;
    assign wb_mem_out    = mem_q;
    assign wb_mem_to_reg = m2r_q;
    assign wb_reg_write  = rw_q;
    assign wb_wr_reg     = wr_q;
    assign halted        = (state_q == HALT);
    assign retire_cnt    = cnt_q;

endmodule

// File: doc/mem_wb_stage_reg.md
Name: mem_wb_stage_reg

Overview:
- Pipeline register between the MEM and WB stages of the demo3 pipelined processor.
- It captures the MEM-stage results and drives the writeback 2:1 data mux directly:
  - wb_alu_out goes to mux input i0.
  - wb_mem_out goes to mux input i1.
  - wb_mem_to_reg goes to the mux select.
- It also owns retire bookkeeping: a valid bit, a halt latch with a RUN/HALT state machine, and a 16-bit retired-instruction counter.

Parameters:
- N, 16, datapath width of the ALU and memory data fields.
- RW, 3, width of the destination register specifier.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- stall  in  1  hold all registers; asserted by the memory system or the hazard unit.
- flush  in  1  squash the incoming MEM instruction (insert a bubble).
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_alu_out  in  N  ALU result from MEM.
- mem_rd_data  in  N  data read from memory.
- mem_mem_to_reg  in  1  writeback select: 0 = ALU, 1 = memory.
- mem_reg_write  in  1  instruction writes the register file.
- mem_wr_reg  in  RW  destination register.
- mem_halt  in  1  instruction is HALT.
- wb_valid  out  1  WB holds a real instruction.
- wb_alu_out  out  N  to writeback mux i0.
- wb_mem_out  out  N  to writeback mux i1.
- wb_mem_to_reg  out  1  to writeback mux Sel.
- wb_reg_write  out  1  register-file write enable, already gated by wb_valid.
- wb_wr_reg  out  RW  register-file write address.
- halted  out  1  processor has retired HALT.
- retire_cnt  out  16  count of retired valid instructions.

Behaviour:
- Reset (rst==0 at a rising edge):
  - wb_valid=0, wb_alu_out=0, wb_mem_out=0, wb_mem_to_reg=0, wb_reg_write=0, wb_wr_reg=0.
  - State returns to RUN, so halted=0.
  - retire_cnt=0.
  - Reset overrides stall, flush and HALT; a reset mid-stall or while halted returns the block to RUN.
- Latency: one cycle. MEM inputs present at edge k appear on the wb_* outputs after edge k.
- State RUN, evaluated in priority order at each edge:
  - stall=1: every register holds its value, including wb_valid. flush is ignored while stall=1; the hazard unit re-asserts it after the stall ends.
  - Else flush=1: wb_valid<=0 and wb_reg_write<=0. Data fields load, but their values are don't-care.
  - Else: all fields load. wb_valid<=mem_valid and wb_reg_write<=mem_reg_write & mem_valid.
- Retire counting and HALT:
  - Each edge where a non-stalled, non-flushed load has mem_valid=1 increments retire_cnt. HALT itself counts.
  - retire_cnt wraps 0xFFFF -> 0x0000 with no flag.
  - When such a load has mem_valid=1 and mem_halt=1, state goes to HALT. halted=1 from that edge onward.
  - A flushed or invalid HALT does not halt the processor.
- State HALT:
  - Registers load bubbles only: wb_valid<=0 and wb_reg_write<=0.
  - retire_cnt frozen; inputs ignored.
  - Leaves HALT only on reset.
- The HALT instruction itself is presented on the wb_* outputs for exactly one cycle. Its wb_reg_write follows mem_reg_write (normally 0).
- wb_mem_to_reg passes through unchanged. Its value when wb_valid=0 is don't-care to the consumer, but is registered deterministically.
- Outputs come straight from registers; there is no combinational path from any input to any output.

Test Plan:
- Reset then run: rst=0 for 2 cycles, then rst=1 with mem_valid=1, mem_alu_out=0x1234, mem_rd_data=0xBEEF, mem_mem_to_reg=1, mem_reg_write=1, mem_wr_reg=5 -> after one edge: wb_alu_out=0x1234, wb_mem_out=0xBEEF, wb_mem_to_reg=1, wb_reg_write=1, wb_wr_reg=5, retire_cnt=1.
- Stall hold: load 0x00AA, then stall=1 for 3 cycles while the inputs change to 0x5555 -> outputs stay 0x00AA and retire_cnt stays unchanged. Dropping stall loads 0x5555.
- Flush: flush=1 with mem_valid=1, mem_reg_write=1 -> wb_valid=0, wb_reg_write=0, retire_cnt unchanged. Case stall=1 and flush=1 together -> full hold.
- HALT: a valid HALT after 4 valid instructions -> halted=1, retire_cnt=5. Further valid inputs -> wb_valid=0 and retire_cnt stays at 5. A flushed HALT -> halted stays 0.
- Counter wrap: force 65535 retirements -> retire_cnt=0xFFFF, then the next retirement gives 0x0000.
- Mid-operation reset: rst=0 while halted with stall=1 -> next edge: halted=0, retire_cnt=0, wb_valid=0, then normal loading resumes.
